// File: rtl/serial_adder_n_if.sv
// Handshake and operand/result bundle for serial_adder_n.
// The master drives start and operands; the slave (the adder) returns status and result.
interface serial_adder_n_if #(
  parameter int WIDTH = 8
);
  logic             i_start;
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_b;
  logic             i_cin;
  logic             o_busy;
  logic             o_done;
  logic [WIDTH-1:0] o_sum;
  logic             o_cout;

  modport master (
    output i_start, i_a, i_b, i_cin,
    input  o_busy, o_done, o_sum, o_cout
  );

  modport slave (
    input  i_start, i_a, i_b, i_cin,
    output o_busy, o_done, o_sum, o_cout
  );
endinterface

// File: rtl/serial_adder_n.sv
// Multi-cycle adder: one DIGIT-bit slice reused over WIDTH/DIGIT clocks with a registered carry.
// Handshake is start/busy/done; result and carry-out hold until the next completion.
module serial_adder_n #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  serial_adder_n_if.slave   bus
);

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
    $error("serial_adder_n: DIGIT must be >= 1 and divide WIDTH exactly");
  end

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic [DIGIT:0]   digit_sum;

  assign digit_sum = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]}
                   + {{DIGIT{1'b0}}, carry_q};

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latches).
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    sum_d   = sum_q;
    cout_d  = cout_q;

    case (state_q)
      RUN: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        // New digit enters at the top so the LSB digit ends up at bit 0 after N steps.
        acc_d   = (acc_q >> DIGIT) | (WIDTH'(digit_sum[DIGIT-1:0]) << (WIDTH - DIGIT));
        carry_d = digit_sum[DIGIT];
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(N - 1)) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          sum_d   = acc_d;
          cout_d  = digit_sum[DIGIT];
          cnt_d   = '0;
        end
      end
      default: begin
        // IDLE and DONE both accept a new request; DONE otherwise falls back to IDLE.
        state_d = IDLE;
        if (bus.i_start) begin
          state_d = RUN;
          a_d     = bus.i_a;
          b_d     = bus.i_b;
          carry_d = bus.i_cin;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign bus.o_busy = busy_q;
  assign bus.o_done = done_q;
  assign bus.o_sum  = sum_q;
  assign bus.o_cout = cout_q;

endmodule
